// File: rtl/rx_bit_timer.sv
// rx_bit_timer
// ------------
// Bit-timing controller for the serial receive path. It sits in front of a
// flex counter, drives that counter's clear / count_enable / rollover_val and
// treats the counter's rollover_flag as the bit-period tick.
//
// Each frame has one start bit (0), DATA_BITS data bits sent LSB first, and one
// stop bit (1). The line is sampled in the middle of each bit. After the stop
// bit, the received byte is presented with a one-cycle data_valid pulse.
//
// Parameters
//   NUM_CNT_BITS  width of the counter rollover value (BIT_PERIOD must fit)
//   BIT_PERIOD    clock cycles per serial bit (even, >= 4)
//   DATA_BITS     data bits per frame
//
// Ports
//   CLK                in   clock, rising edge
//   nRST               in   asynchronous active-low reset
//   start_detected     in   falling-edge-of-line pulse from the synchroniser
//   serial_in          in   synchronised serial line, idle high
//   cnt_rollover_flag  in   bit-period tick from the flex counter
//   cnt_clear          out  counter clear
//   cnt_enable         out  counter count enable
//   cnt_rollover_val   out  counter rollover value
//   shift_strobe       out  one-cycle pulse per sampled bit (data and stop)
//   rx_data            out  last received byte, held until the next frame completes
//   data_valid         out  one-cycle pulse when rx_data has just been updated
//   framing_error      out  stop bit was sampled as 0; held until the next start
//   busy               out  frame in progress
module rx_bit_timer #(
  parameter int NUM_CNT_BITS = 4,
  parameter int BIT_PERIOD   = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    start_detected,
  input  logic                    serial_in,
  input  logic                    cnt_rollover_flag,
  output logic                    cnt_clear,
  output logic                    cnt_enable,
  output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
  output logic                    shift_strobe,
  output logic [DATA_BITS-1:0]    rx_data,
  output logic                    data_valid,
  output logic                    framing_error,
  output logic                    busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [NUM_CNT_BITS-1:0] FULL_VAL = NUM_CNT_BITS'(BIT_PERIOD);
  localparam logic [NUM_CNT_BITS-1:0] HALF_VAL = NUM_CNT_BITS'(BIT_PERIOD / 2);
  localparam logic [IDX_W-1:0]        STOP_IDX = IDX_W'(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALF = 3'd1,
    CLR  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   strobe_q, strobe_d;
  logic                   ferr_q, ferr_d;

  // Each bit-period tick in RUN is one line sample. The strobe is registered,
  // so it appears in the cycle after the sample.
  logic sample;
  assign sample = (state_q == RUN) && cnt_rollover_flag;

  always_comb begin
    state_d          = state_q;
    bit_idx_d        = bit_idx_q;
    shift_d          = shift_q;
    rx_data_d        = rx_data_q;
    ferr_d           = ferr_q;
    strobe_d         = sample;
    cnt_clear        = 1'b1;
    cnt_enable       = 1'b0;
    cnt_rollover_val = FULL_VAL;
    busy             = 1'b0;
    data_valid       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_detected) begin
          state_d = HALF;
          ferr_d  = 1'b0;
        end
      end

      // Count half a bit so that later samples land mid-bit. The line must
      // still be low here, otherwise the start pulse was a glitch.
      HALF: begin
        cnt_clear        = 1'b0;
        cnt_enable       = 1'b1;
        cnt_rollover_val = HALF_VAL;
        busy             = 1'b1;
        if (cnt_rollover_flag) begin
          state_d = serial_in ? IDLE : CLR;
        end
      end

      // Restart the counter from zero so the full-period ticks are phased
      // relative to the mid-start-bit sample.
      CLR: begin
        busy      = 1'b1;
        bit_idx_d = '0;
        state_d   = RUN;
      end

      RUN: begin
        cnt_clear  = 1'b0;
        cnt_enable = 1'b1;
        busy       = 1'b1;
        if (cnt_rollover_flag) begin
          if (bit_idx_q == STOP_IDX) begin
            // Stop-bit sample. The index is left at STOP_IDX instead of
            // being incremented, so it cannot wrap when DATA_BITS+1 is a
            // power of two.
            rx_data_d = shift_q;
            ferr_d    = ~serial_in;
            state_d   = DONE;
          end else begin
            // Bits arrive LSB first, so shift in from the MSB side.
            shift_d   = {serial_in, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      DONE: begin
        data_valid = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      strobe_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      strobe_q  <= strobe_d;
      ferr_q    <= ferr_d;
    end
  end

  assign shift_strobe  = strobe_q;
  assign rx_data       = rx_data_q;
  assign framing_error = ferr_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Testbench for rx_bit_timer. A behavioural flex counter closes the loop
// around the DUT. Expected {framing_error, rx_data} values are queued whenever
// a frame is driven. Observed values are queued on every data_valid pulse.
// Each test drains both queues and compares them.
module tb_rx_bit_timer;

  localparam int NCB = 4;
  localparam int BP  = 10;
  localparam int DB  = 8;
  localparam int FRAME_CYC = (DB + 2) * BP;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           start_detected = 1'b0;
  logic           serial_in = 1'b1;
  logic           cnt_rollover_flag;
  logic           cnt_clear, cnt_enable, shift_strobe, data_valid, framing_error, busy;
  logic [NCB-1:0] cnt_rollover_val;
  logic [DB-1:0]  rx_data;

  logic [NCB-1:0] cnt_q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int dv_cnt = 0;
  int gap_bad = 0;
  int last_strobe = -1;
  logic           busy_at_dv = 1'b0;
  logic           clear_at_dv = 1'b0;
  logic [NCB-1:0] half_rv = '0;
  logic [DB:0]    exp_q[$];
  logic [DB:0]    obs_q[$];
  logic [DB:0]    exp_item, obs_item;

  always #5 clk = ~clk;

  rx_bit_timer #(.NUM_CNT_BITS(NCB), .BIT_PERIOD(BP), .DATA_BITS(DB)) dut (
    .CLK               (clk),
    .nRST              (nrst),
    .start_detected    (start_detected),
    .serial_in         (serial_in),
    .cnt_rollover_flag (cnt_rollover_flag),
    .cnt_clear         (cnt_clear),
    .cnt_enable        (cnt_enable),
    .cnt_rollover_val  (cnt_rollover_val),
    .shift_strobe      (shift_strobe),
    .rx_data           (rx_data),
    .data_valid        (data_valid),
    .framing_error     (framing_error),
    .busy              (busy)
  );

  // Flex counter model. The flag is registered and goes high in the cycle
  // where the count equals the rollover value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      cnt_rollover_flag <= 1'b0;
    end else if (cnt_clear) begin
      cnt_q <= '0;
      cnt_rollover_flag <= 1'b0;
    end else if (cnt_enable) begin
      if (cnt_q == cnt_rollover_val) begin
        cnt_q <= NCB'(1);
        cnt_rollover_flag <= (cnt_rollover_val == NCB'(1));
      end else begin
        cnt_q <= cnt_q + NCB'(1);
        cnt_rollover_flag <= ((cnt_q + NCB'(1)) == cnt_rollover_val);
      end
    end
  end

  // Advance one clock, sample 1 time unit after the edge, and record events.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (shift_strobe === 1'b1) begin
      strobe_cnt++;
      if (last_strobe >= 0 && (cyc - last_strobe) != BP) gap_bad++;
      last_strobe = cyc;
    end
    if (data_valid === 1'b1) begin
      dv_cnt++;
      obs_q.push_back({framing_error, rx_data});
      busy_at_dv  = busy;
      clear_at_dv = cnt_clear;
    end
  endtask

  task automatic clear_stats();
    strobe_cnt = 0;
    dv_cnt = 0;
    gap_bad = 0;
    last_strobe = -1;
    obs_q.delete();
  endtask

  // Drive one frame: start bit, data LSB first, then the stop bit. Each bit is
  // held for BP cycles. start_detected is sampled on the first edge.
  // spur adds stray start pulses during RUN and on the DONE cycle.
  // abort_at > 0 stops driving once that many strobes have been seen.
  task automatic send_frame(input logic [DB-1:0] data, input logic stop,
                            input bit spur, input int abort_at);
    int b;
    last_strobe = -1;
    if (abort_at == 0) exp_q.push_back({~stop, data});
    for (int k = 0; k < FRAME_CYC; k++) begin
      b = k / BP;
      serial_in = (b == 0) ? 1'b0 : ((b <= DB) ? data[b-1] : stop);
      start_detected = (k == 0) || (spur && (k == 35 || k == 62 || k == FRAME_CYC - 1));
      cycle();
      if (k == 0) half_rv = cnt_rollover_val;
      if (abort_at != 0 && strobe_cnt == abort_at) break;
    end
    serial_in = 1'b1;
    start_detected = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    serial_in = 1'b1;
    start_detected = 1'b0;
    cycle();
    cycle();
    checks++; if (cnt_clear !== 1'b1) begin errors++; $display("FAIL reset_clear: got %b expected 1", cnt_clear); end
    checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", cnt_enable); end
    checks++; if (cnt_rollover_val !== NCB'(BP)) begin errors++; $display("FAIL reset_rollover_val: got %0d expected %0d", cnt_rollover_val, BP); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (shift_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", shift_strobe); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    nrst = 1'b1;
    repeat (3) cycle();
    checks++; if (cnt_clear !== 1'b1) begin errors++; $display("FAIL idle_clear: got %b expected 1", cnt_clear); end
  endtask

  task automatic test_nominal();
    clear_stats();
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    repeat (3) cycle();
    checks++; if (half_rv !== NCB'(BP / 2)) begin errors++; $display("FAIL nominal_half_rollover: got %0d expected %0d", half_rv, BP / 2); end
    checks++; if (strobe_cnt != DB + 1) begin errors++; $display("FAIL nominal_strobe_count: got %0d expected %0d", strobe_cnt, DB + 1); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL nominal_strobe_spacing: got %0d bad gaps expected 0", gap_bad); end
    checks++; if (dv_cnt != 1) begin errors++; $display("FAIL nominal_data_valid_count: got %0d expected 1", dv_cnt); end
    checks++; if (busy_at_dv !== 1'b0) begin errors++; $display("FAIL nominal_busy_in_done: got %b expected 0", busy_at_dv); end
    checks++; if (clear_at_dv !== 1'b1) begin errors++; $display("FAIL nominal_clear_in_done: got %b expected 1", clear_at_dv); end
    while (exp_q.size() > 0) begin
      exp_item = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL nominal_sb: got no data_valid expected fe/data %h", exp_item); end
      else begin
        obs_item = obs_q.pop_front();
        if (obs_item !== exp_item) begin errors++; $display("FAIL nominal_sb: got fe/data %h expected %h", obs_item, exp_item); end
      end
    end
  endtask

  task automatic test_stop_error();
    clear_stats();
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    repeat (5) cycle();
    checks++; if (strobe_cnt != DB + 1) begin errors++; $display("FAIL stoperr_strobe_count: got %0d expected %0d", strobe_cnt, DB + 1); end
    checks++; if (dv_cnt != 1) begin errors++; $display("FAIL stoperr_data_valid_count: got %0d expected 1", dv_cnt); end
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL stoperr_held: got %b expected 1", framing_error); end
    while (exp_q.size() > 0) begin
      exp_item = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL stoperr_sb: got no data_valid expected fe/data %h", exp_item); end
      else begin
        obs_item = obs_q.pop_front();
        if (obs_item !== exp_item) begin errors++; $display("FAIL stoperr_sb: got fe/data %h expected %h", obs_item, exp_item); end
      end
    end
  endtask

  task automatic test_false_start();
    clear_stats();
    serial_in = 1'b0;
    start_detected = 1'b1;
    cycle();
    start_detected = 1'b0;
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL false_fe_cleared: got %b expected 0", framing_error); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_busy_in_half: got %b expected 1", busy); end
    cycle();
    serial_in = 1'b1;
    repeat (10) cycle();
    checks++; if (strobe_cnt != 0) begin errors++; $display("FAIL false_strobes: got %0d expected 0", strobe_cnt); end
    checks++; if (dv_cnt != 0) begin errors++; $display("FAIL false_data_valid: got %0d expected 0", dv_cnt); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL false_rx_data: got %h expected 3c", rx_data); end
    checks++; if (cnt_clear !== 1'b1) begin errors++; $display("FAIL false_clear: got %b expected 1", cnt_clear); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    send_frame(8'h5A, 1'b1, 1'b0, 4);
    checks++; if (strobe_cnt != 4) begin errors++; $display("FAIL midrst_strobes_before: got %0d expected 4", strobe_cnt); end
    nrst = 1'b0;
    #1;
    checks++; if (cnt_clear !== 1'b1) begin errors++; $display("FAIL midrst_clear: got %b expected 1", cnt_clear); end
    checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL midrst_enable: got %b expected 0", cnt_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
    checks++; if (cnt_rollover_val !== NCB'(BP)) begin errors++; $display("FAIL midrst_rollover_val: got %0d expected %0d", cnt_rollover_val, BP); end
    cycle();
    checks++; if (dv_cnt != 0) begin errors++; $display("FAIL midrst_data_valid: got %0d expected 0", dv_cnt); end
    nrst = 1'b1;
    cycle();
    clear_stats();
    send_frame(8'h81, 1'b1, 1'b0, 0);
    repeat (3) cycle();
    checks++; if (strobe_cnt != DB + 1) begin errors++; $display("FAIL midrst_next_strobes: got %0d expected %0d", strobe_cnt, DB + 1); end
    checks++; if (dv_cnt != 1) begin errors++; $display("FAIL midrst_next_data_valid: got %0d expected 1", dv_cnt); end
    while (exp_q.size() > 0) begin
      exp_item = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midrst_sb: got no data_valid expected fe/data %h", exp_item); end
      else begin
        obs_item = obs_q.pop_front();
        if (obs_item !== exp_item) begin errors++; $display("FAIL midrst_sb: got fe/data %h expected %h", obs_item, exp_item); end
      end
    end
  endtask

  task automatic test_spurious();
    clear_stats();
    send_frame(8'h6B, 1'b1, 1'b1, 0);
    repeat (3) cycle();
    checks++; if (strobe_cnt != DB + 1) begin errors++; $display("FAIL spur_strobe_count: got %0d expected %0d", strobe_cnt, DB + 1); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL spur_strobe_spacing: got %0d bad gaps expected 0", gap_bad); end
    checks++; if (dv_cnt != 1) begin errors++; $display("FAIL spur_data_valid_count: got %0d expected 1", dv_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_idle_after: got busy %b expected 0", busy); end
    while (exp_q.size() > 0) begin
      exp_item = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL spur_sb: got no data_valid expected fe/data %h", exp_item); end
      else begin
        obs_item = obs_q.pop_front();
        if (obs_item !== exp_item) begin errors++; $display("FAIL spur_sb: got fe/data %h expected %h", obs_item, exp_item); end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    repeat (3) cycle();
    checks++; if (strobe_cnt != 2 * (DB + 1)) begin errors++; $display("FAIL b2b_strobe_count: got %0d expected %0d", strobe_cnt, 2 * (DB + 1)); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL b2b_strobe_spacing: got %0d bad gaps expected 0", gap_bad); end
    checks++; if (dv_cnt != 2) begin errors++; $display("FAIL b2b_data_valid_count: got %0d expected 2", dv_cnt); end
    while (exp_q.size() > 0) begin
      exp_item = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_sb: got no data_valid expected fe/data %h", exp_item); end
      else begin
        obs_item = obs_q.pop_front();
        if (obs_item !== exp_item) begin errors++; $display("FAIL b2b_sb: got fe/data %h expected %h", obs_item, exp_item); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stop_error();
    test_false_start();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
